// File: rtl/bgr_pkg.sv
// Shared types and reset values for the bandgap start-up controller.
package bgr_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KICK   = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        READY  = 3'd4,
        FAIL   = 3'd5
    } bgr_state_t;

    localparam bgr_state_t RST_STATE = IDLE;
    localparam logic RST_PORST = 1'b0;
    localparam logic RST_READY = 1'b0;
    localparam logic RST_FAIL  = 1'b0;
    localparam logic RST_SYNC  = 1'b0;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bgr_sync2.sv
// Two-flop synchronizer for the asynchronous vbg_ok comparator flag.
module bgr_sync2
    import bgr_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_SYNC;
            q    <= RST_SYNC;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bgr_startup_ctrl.sv
// Bandgap start-up kick, settle, qualification and supervision FSM with bounded retries.
module bgr_startup_ctrl
    import bgr_pkg::*;
#(
    parameter int PULSE_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 256,
    parameter int OK_CYCLES     = 8,
    parameter int DROP_CYCLES   = 4,
    parameter int MAX_RETRIES   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic vbg_ok,
    output logic porst,
    output logic bgr_ready,
    output logic bgr_fail,
    output logic [((MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1)-1:0] retry_cnt
);

    localparam int RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int MAXP = max2(max2(PULSE_CYCLES, SETTLE_CYCLES), max2(OK_CYCLES, DROP_CYCLES));
    localparam int CW   = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] LD_PULSE  = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] LD_SETTLE = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] LD_OK     = CW'(OK_CYCLES - 1);
    localparam logic [CW-1:0] LD_DROP   = CW'(DROP_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    bgr_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [RW-1:0] retry_nxt;
    logic          ok_s;
    logic          cnt_zero;

    bgr_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (vbg_ok),
        .q   (ok_s)
    );

    assign cnt_zero = (cnt == '0);

    // One down-counter times every state; it is reloaded with (N-1) on each state entry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_cnt;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = KICK;
                    cnt_nxt   = LD_PULSE;
                end
                KICK: begin
                    if (cnt_zero) begin
                        state_nxt = SETTLE;
                        cnt_nxt   = LD_SETTLE;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_zero) begin
                        state_nxt = CHECK;
                        cnt_nxt   = LD_OK;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                CHECK: begin
                    if (!ok_s) begin
                        if (retry_cnt < RETRY_MAX) begin
                            retry_nxt = retry_cnt + 1'b1;
                            state_nxt = KICK;
                            cnt_nxt   = LD_PULSE;
                        end else begin
                            state_nxt = FAIL;
                            cnt_nxt   = '0;
                        end
                    end else if (cnt_zero) begin
                        state_nxt = READY;
                        cnt_nxt   = LD_DROP;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                READY: begin
                    if (ok_s) begin
                        cnt_nxt = LD_DROP;
                    end else if (cnt_zero) begin
                        state_nxt = KICK;
                        cnt_nxt   = LD_PULSE;
                        retry_nxt = '0;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                FAIL: begin
                    state_nxt = FAIL;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RST_STATE;
            cnt       <= '0;
            retry_cnt <= '0;
            porst     <= RST_PORST;
            bgr_ready <= RST_READY;
            bgr_fail  <= RST_FAIL;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            porst     <= (state_nxt == KICK);
            bgr_ready <= (state_nxt == READY);
            bgr_fail  <= (state_nxt == FAIL);
        end
    end

endmodule
